head_table_lookup: RTL and testbench

//  Lookup stage directly upstream of the data table. Takes hashed commands, reads the bucket's head

---
 rtl/head_table_lookup.sv | 224 ++++++++++++++++++++++
 tb/tb_head_table_lookup.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/head_table_lookup.sv
// Head table lookup stage: reads each command's bucket head pointer from the head table,
// folds in head-table writes issued while the command is in flight or buffered, and bulk-clears the table.
module head_table_lookup #(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 16,
  parameter int OPCODE_WIDTH   = 2,
  parameter int BUCKET_WIDTH   = 8,
  parameter int HEAD_PTR_WIDTH = 8,
  parameter int RAM_LATENCY    = 2,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [KEY_WIDTH-1:0]      in_key_i,
  input  logic [VALUE_WIDTH-1:0]    in_value_i,
  input  logic [OPCODE_WIDTH-1:0]   in_opcode_i,
  input  logic [BUCKET_WIDTH-1:0]   in_bucket_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [KEY_WIDTH-1:0]      out_key_o,
  output logic [VALUE_WIDTH-1:0]    out_value_o,
  output logic [OPCODE_WIDTH-1:0]   out_opcode_o,
  output logic [BUCKET_WIDTH-1:0]   out_bucket_o,
  output logic [HEAD_PTR_WIDTH-1:0] out_head_ptr_o,
  output logic                      out_head_ptr_val_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  input  logic [BUCKET_WIDTH-1:0]   ht_wr_addr_i,
  input  logic [HEAD_PTR_WIDTH-1:0] ht_wr_ptr_i,
  input  logic                      ht_wr_ptr_val_i,
  input  logic                      ht_wr_en_i,
  input  logic                      clear_run_i,
  output logic                      clear_done_o,
  output logic [1:0]                dbg_state_o
);

  localparam int DEPTH = 2 ** BUCKET_WIDTH;
  localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]      key;
    logic [VALUE_WIDTH-1:0]    value;
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [BUCKET_WIDTH-1:0]   bucket;
    logic [HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                      head_val;
  } entry_t;

  state_t                    state;
  logic [BUCKET_WIDTH-1:0]   clr_cnt;
  logic                      ready_en_q;

  logic [HEAD_PTR_WIDTH:0]   head_mem [0:DEPTH-1];
  logic [HEAD_PTR_WIDTH:0]   wr_head;

  logic                      s1_valid;
  logic                      s2_valid;
  entry_t                    s1;
  entry_t                    s2;
  entry_t                    in_entry;

  entry_t                    fifo_mem [0:OUT_FIFO_DEPTH-1];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          fifo_used;
  entry_t                    head_entry;

  logic [1:0]                inflight;
  logic [OCC_W-1:0]          occupancy;
  logic                      accept;
  logic                      push;
  logic                      pop;

  // Valid/ready: a transfer happens on a cycle where valid && ready are both high; the sender
  // holds its payload while valid is high and ready is low. Both sides of this block follow that rule.
  assign accept = in_valid_i && in_ready_o;
  assign push   = s2_valid;
  assign pop    = out_valid_o && out_ready_i;

  assign wr_head   = {ht_wr_ptr_i, ht_wr_ptr_val_i};
  assign inflight  = {1'b0, s1_valid} + {1'b0, s2_valid};
  assign occupancy = OCC_W'(fifo_used) + OCC_W'(inflight);

  // Credit counts in-flight reads as occupied, and ignores a same-cycle pop, so the FIFO cannot overflow.
  assign in_ready_o = ready_en_q && (state == S_IDLE) && (occupancy < OCC_W'(OUT_FIFO_DEPTH));

  function automatic entry_t fwd(input entry_t e, input logic wr_en,
                                 input logic [BUCKET_WIDTH-1:0] wr_addr,
                                 input logic [HEAD_PTR_WIDTH:0] wr_data);
    entry_t r;
    r = e;
    if (wr_en && (e.bucket == wr_addr)) begin
      {r.head_ptr, r.head_val} = wr_data;
    end
    return r;
  endfunction

  always_comb begin
    in_entry          = '0;
    in_entry.key      = in_key_i;
    in_entry.value    = in_value_i;
    in_entry.opcode   = in_opcode_i;
    in_entry.bucket   = in_bucket_i;
    {in_entry.head_ptr, in_entry.head_val} = head_mem[in_bucket_i];
  end

  // Table contents are intentionally not reset; a bulk clear is the way to initialise them.
  always_ff @(posedge clk_i) begin
    if (state == S_CLEAR) begin
      head_mem[clr_cnt] <= '0;
    end else if (ht_wr_en_i) begin
      head_mem[ht_wr_addr_i] <= wr_head;
    end
  end

  // Two-stage read path; each stage picks up any write to its bucket in that cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        s1 <= fwd(in_entry, ht_wr_en_i, ht_wr_addr_i, wr_head);
      end
      s2 <= fwd(s1, ht_wr_en_i, ht_wr_addr_i, wr_head);
    end
  end

  // First-word-fall-through buffer. Every slot keeps absorbing writes, so an entry always carries
  // the newest head for its bucket up to (but not including) the cycle it is popped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_used <= '0;
    end else begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
        fifo_mem[i] <= fwd(fifo_mem[i], ht_wr_en_i, ht_wr_addr_i, wr_head);
      end
      if (push) begin
        fifo_mem[wr_ptr] <= fwd(s2, ht_wr_en_i, ht_wr_addr_i, wr_head);
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_used <= fifo_used + CNT_W'(1);
        2'b01:   fifo_used <= fifo_used - CNT_W'(1);
        default: fifo_used <= fifo_used;
      endcase
    end
  end

  assign head_entry         = fifo_mem[rd_ptr];
  assign out_key_o          = head_entry.key;
  assign out_value_o        = head_entry.value;
  assign out_opcode_o       = head_entry.opcode;
  assign out_bucket_o       = head_entry.bucket;
  assign out_head_ptr_o     = head_entry.head_ptr;
  assign out_head_ptr_val_o = head_entry.head_val;
  assign out_valid_o        = (fifo_used != '0);

  // Clear sequencer. A clear request in IDLE is taken even if a command is accepted in the same
  // cycle; DRAIN then waits for that command to leave before the table is wiped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      clr_cnt      <= '0;
      clear_done_o <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      clear_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_run_i) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!s1_valid && !s2_valid && (fifo_used == '0)) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == '1) begin
            clear_done_o <= 1'b1;
            state        <= S_IDLE;
          end else begin
            clr_cnt <= clr_cnt + BUCKET_WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state;

  a_no_write_in_clear: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !((state == S_CLEAR) && ht_wr_en_i));
  a_inflight_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    32'(inflight) <= RAM_LATENCY);
  a_fifo_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    32'(fifo_used) <= OUT_FIFO_DEPTH);

endmodule

// File: tb/tb_head_table_lookup.sv
// Bench for head_table_lookup: directed vector table for forwarding timing, hand-written
// sequences for clear, back-pressure and reset, and a scoreboard with a reference head table.
module tb_head_table_lookup;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_key;
  logic [15:0] in_value;
  logic [1:0]  in_opcode;
  logic [7:0]  in_bucket;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_key;
  logic [15:0] out_value;
  logic [1:0]  out_opcode;
  logic [7:0]  out_bucket;
  logic [7:0]  out_head_ptr;
  logic        out_head_ptr_val;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  ht_wr_addr;
  logic [7:0]  ht_wr_ptr;
  logic        ht_wr_ptr_val;
  logic        ht_wr_en;
  logic        clear_run;
  logic        clear_done;
  logic [1:0]  dbg_state;

  head_table_lookup dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .in_key_i           (in_key),
    .in_value_i         (in_value),
    .in_opcode_i        (in_opcode),
    .in_bucket_i        (in_bucket),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .out_key_o          (out_key),
    .out_value_o        (out_value),
    .out_opcode_o       (out_opcode),
    .out_bucket_o       (out_bucket),
    .out_head_ptr_o     (out_head_ptr),
    .out_head_ptr_val_o (out_head_ptr_val),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .ht_wr_addr_i       (ht_wr_addr),
    .ht_wr_ptr_i        (ht_wr_ptr),
    .ht_wr_ptr_val_i    (ht_wr_ptr_val),
    .ht_wr_en_i         (ht_wr_en),
    .clear_run_i        (clear_run),
    .clear_done_o       (clear_done),
    .dbg_state_o        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  localparam int W = 58;
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [8:0]   model [0:255];
  logic [8:0]   pop_head [0:255];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic exact_lat = 1'b0;
  logic [8:0] last_head;

  typedef struct {
    logic [7:0] bucket;
    logic [7:0] wr_addr;
    logic [7:0] wr_ptr;
    logic       wr_val;
    int         wr_off;
    logic [7:0] exp_ptr;
    logic       exp_val;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic [7:0] b);
    in_key    = $urandom;
    in_value  = 16'($urandom);
    in_opcode = 2'($urandom);
    in_bucket = b;
  endtask

  task automatic set_wr(input logic en, input logic [7:0] a, input logic [7:0] p, input logic v);
    ht_wr_en      = en;
    ht_wr_addr    = a;
    ht_wr_ptr     = p;
    ht_wr_ptr_val = v;
  endtask

  // Observes the current cycle (inputs already driven), updates the scoreboard, advances one clock.
  task automatic cycle();
    int occ;
    int a;
    logic [W-1:0] e;
    occ = exp_q.size();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_without_cmd", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("out_fields", 64'({out_key, out_value, out_opcode, out_bucket}), 64'(e));
        chk("out_head", 64'({out_head_ptr, out_head_ptr_val}), 64'(model[e[7:0]]));
        if (exact_lat) chk("latency", 64'(cyc - a), 64'(3));
        else           chk("latency_min", 64'(cyc - a >= 3), 64'(1));
        last_head = {out_head_ptr, out_head_ptr_val};
        pop_head[e[7:0]] = last_head;
        pop_cnt++;
      end
    end
    if (in_valid && in_ready) begin
      chk("credit", 64'(occ < 4), 64'(1));
      exp_q.push_back({in_key, in_value, in_opcode, in_bucket});
      acc_q.push_back(cyc);
      acc_cnt++;
    end
    if (ht_wr_en) model[ht_wr_addr] = {ht_wr_ptr, ht_wr_ptr_val};
    if (clear_done) begin
      for (int i = 0; i < 256; i++) model[i] = '0;
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_clear_done"}, 64'(clear_done), 64'(0));
    chk({tag, "_out_data"}, 64'({out_key, out_value, out_opcode, out_bucket}), 64'(0));
    chk({tag, "_out_head"}, 64'({out_head_ptr, out_head_ptr_val}), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- test sequence ----------------
  vec_t vecs [7];
  int c0, d0, a0, p0;

  initial begin
    // Forwarding vectors: lookup issued at offset 0, one write at wr_off relative to it.
    vecs[0] = '{8'd9,   8'd9,  8'h40, 1'b1,  0, 8'h40, 1'b1};
    vecs[1] = '{8'd9,   8'd9,  8'h40, 1'b1,  1, 8'h40, 1'b1};
    vecs[2] = '{8'd9,   8'd9,  8'h40, 1'b1,  2, 8'h40, 1'b1};
    vecs[3] = '{8'd9,   8'd9,  8'h40, 1'b1, -1, 8'h40, 1'b1};
    vecs[4] = '{8'd9,   8'd10, 8'h40, 1'b1,  1, 8'h00, 1'b0};
    vecs[5] = '{8'd9,   8'd9,  8'h40, 1'b1,  3, 8'h00, 1'b0};
    vecs[6] = '{8'd9,   8'd9,  8'h7f, 1'b0,  2, 8'h7f, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; clear_run = 1'b0;
    set_cmd(8'd0);
    set_wr(1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      model[i] = '0;
      pop_head[i] = '1;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset_state", 64'(dbg_state), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // ---- Test 1: clear timing, then lookups at both ends of the table ----
    set_wr(1'b1, 8'd0, 8'h33, 1'b1);   cycle();
    set_wr(1'b1, 8'd255, 8'h44, 1'b1); cycle();
    set_wr(1'b0, 8'd0, 8'd0, 1'b0);
    clear_run = 1'b1; c0 = cyc; cycle();
    clear_run = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      if (!clear_done) chk("ready_low_in_clear", 64'(in_ready), 64'(0));
      cycle();
    end
    chk("clear_done_seen", 64'(done_cnt - d0), 64'(1));
    chk("clear_latency", 64'(done_cyc - c0), 64'(258));
    idle(3);
    chk("clear_done_single", 64'(done_cnt - d0), 64'(1));
    out_ready = 1'b1;
    in_valid = 1'b1; set_cmd(8'd0);   cycle();
    set_cmd(8'd255);                  cycle();
    in_valid = 1'b0;
    idle(6);
    chk("clr_head_b0", 64'(pop_head[0]), 64'(0));
    chk("clr_head_b255", 64'(pop_head[255]), 64'(0));

    // ---- Test 2: eight back-to-back lookups of one bucket ----
    set_wr(1'b1, 8'd5, 8'h21, 1'b1); cycle();
    set_wr(1'b0, 8'd0, 8'd0, 1'b0);
    exact_lat = 1'b1;
    a0 = acc_cnt; p0 = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; set_cmd(8'd5);
      chk("b2b_ready", 64'(in_ready), 64'(1));
      cycle();
    end
    in_valid = 1'b0;
    idle(5);
    exact_lat = 1'b0;
    chk("b2b_accepts", 64'(acc_cnt - a0), 64'(8));
    chk("b2b_pops", 64'(pop_cnt - p0), 64'(8));
    chk("b2b_head", 64'(pop_head[5]), 64'({8'h21, 1'b1}));

    // ---- Test 3: forwarding vector table ----
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      in_valid = 1'b0;
      set_wr(1'b1, 8'd9, 8'd0, 1'b0);  cycle();
      set_wr(1'b1, 8'd10, 8'd0, 1'b0); cycle();
      set_wr(1'b0, 8'd0, 8'd0, 1'b0);  cycle();
      p0 = pop_cnt;
      for (int c = -1; c <= 5; c++) begin
        in_valid = (c == 0);
        if (c == 0) set_cmd(vecs[v].bucket);
        set_wr(c == vecs[v].wr_off, vecs[v].wr_addr, vecs[v].wr_ptr, vecs[v].wr_val);
        cycle();
      end
      in_valid = 1'b0;
      set_wr(1'b0, 8'd0, 8'd0, 1'b0);
      chk($sformatf("vec%0d_pops", v), 64'(pop_cnt - p0), 64'(1));
      chk($sformatf("vec%0d_head", v), 64'(last_head), 64'({vecs[v].exp_ptr, vecs[v].exp_val}));
    end

    // ---- Test 4: fill with back-pressure, forward into a buffered entry ----
    out_ready = 1'b0;
    a0 = acc_cnt; p0 = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; set_cmd(8'(1 + acc_cnt - a0));
      cycle();
    end
    in_valid = 1'b0;
    chk("fill_accepts", 64'(acc_cnt - a0), 64'(4));
    chk("fill_ready_low", 64'(in_ready), 64'(0));
    chk("fill_valid", 64'(out_valid), 64'(1));
    set_wr(1'b1, 8'd3, 8'h11, 1'b1); cycle();
    set_wr(1'b0, 8'd0, 8'd0, 1'b0);
    out_ready = 1'b1;
    idle(6);
    chk("fill_pops", 64'(pop_cnt - p0), 64'(4));
    chk("fill_fwd_b3", 64'(pop_head[3]), 64'({8'h11, 1'b1}));

    // ---- Test 5: random traffic with random back-pressure and writes ----
    a0 = acc_cnt;
    for (int i = 0; i < 20000 && !((acc_cnt - a0) >= 1000 && exp_q.size() == 0); i++) begin
      in_valid = ((acc_cnt - a0) < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      set_cmd(8'($urandom_range(0, 15)));
      out_ready = 1'($urandom_range(0, 1));
      set_wr($urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)));
      cycle();
    end
    in_valid = 1'b0;
    set_wr(1'b0, 8'd0, 8'd0, 1'b0);
    chk("rand_accepts", 64'(acc_cnt - a0), 64'(1000));
    chk("rand_drained", 64'(exp_q.size()), 64'(0));

    // ---- Test 6: clear with buffered entries, then reset mid-clear ----
    out_ready = 1'b0;
    set_wr(1'b1, 8'd20, 8'h50, 1'b1); cycle();
    set_wr(1'b1, 8'd21, 8'h51, 1'b1); cycle();
    set_wr(1'b1, 8'd22, 8'h52, 1'b1); cycle();
    set_wr(1'b0, 8'd0, 8'd0, 1'b0);
    p0 = pop_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; set_cmd(8'(20 + i)); cycle();
    end
    in_valid = 1'b0;
    clear_run = 1'b1; cycle();
    clear_run = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      out_ready = (i >= 5);
      in_valid = 1'b1; set_cmd(8'd30);
      if (!clear_done) chk("ready_low_drain", 64'(in_ready), 64'(0));
      if (clear_done) in_valid = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    chk("drain_clear_done", 64'(done_cnt - d0), 64'(1));
    chk("drain_pops", 64'(pop_cnt - p0), 64'(3));
    chk("drain_b20", 64'(pop_head[20]), 64'({8'h50, 1'b1}));
    chk("drain_b21", 64'(pop_head[21]), 64'({8'h51, 1'b1}));
    chk("drain_b22", 64'(pop_head[22]), 64'({8'h52, 1'b1}));
    idle(4);

    clear_run = 1'b1; cycle();
    clear_run = 1'b0;
    d0 = done_cnt;
    idle(100);
    chk("midclear_ready_low", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    exp_q.delete();
    acc_q.delete();
    rst_n = 1'b1;
    idle(300);
    chk("no_done_after_reset", 64'(done_cnt - d0), 64'(0));
    chk("ready_after_reset", 64'(in_ready), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
